// File: rtl/snes_mapper_pkg.sv
// Shared types for the SNES window mapper: config field codes, attribute bit positions,
// the window record and the commit FSM states.
package snes_mapper_pkg;

  localparam int WIN_ADDR_W = 24;
  localparam int ATTR_W     = 4;

  localparam logic [1:0] CFG_BASE   = 2'd0;
  localparam logic [1:0] CFG_MASK   = 2'd1;
  localparam logic [1:0] CFG_TARGET = 2'd2;
  localparam logic [1:0] CFG_ATTR   = 2'd3;

  localparam int ATTR_EN    = 0;
  localparam int ATTR_WR    = 1;
  localparam int ATTR_SRAM  = 2;
  localparam int ATTR_LOROM = 3;

  typedef logic [WIN_ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t             base;
    addr_t             mask;
    addr_t             target;
    logic [ATTR_W-1:0] attr;
  } win_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/mapper_window_match.sv
// One window's combinational compare, offset extraction (optional LoROM A15 drop) and target add.
// Zero latency, no flow control; the top registers the selected result.
module mapper_window_match
  import snes_mapper_pkg::*;
(
  input  addr_t addr,
  input  win_t  win,
  output logic  hit,
  output addr_t rom_addr
);

  addr_t off_raw;
  addr_t off;

  always_comb begin
    off_raw = addr & ~win.mask;
    // LoROM banks are 32 KiB at A15=1, so A15 is squeezed out and upper bits slide down one place.
    if (win.attr[ATTR_LOROM]) begin
      off = {1'b0, off_raw[WIN_ADDR_W-1:16], off_raw[14:0]};
    end else begin
      off = off_raw;
    end
    hit      = win.attr[ATTR_EN] && (((addr ^ win.base) & win.mask) == '0);
    rom_addr = win.target + off;
  end

endmodule

// File: rtl/snes_window_mapper.sv
// Programmable SNES->ROM address mapper: shadow/active window tables, priority select, commit FSM.
// One-cycle registered lookup every cycle; commits wait for snes_idle, no backpressure to the SNES side.
module snes_window_mapper
  import snes_mapper_pkg::*;
#(
  parameter int NUM_WIN = 8,
  parameter int ADDR_W  = WIN_ADDR_W,
  parameter int MISS_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              snes_req,
  input  logic              snes_idle,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_win,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic              cfg_clr_miss,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [3:0]        win_idx,
  output logic              map_valid,
  output logic              commit_pending,
  output logic [MISS_W-1:0] miss_cnt
);

  win_t          shadow     [NUM_WIN];
  win_t          shadow_nxt [NUM_WIN];
  win_t          active     [NUM_WIN];
  commit_state_e state, state_nxt;
  logic          do_copy;

  logic [NUM_WIN-1:0] hit_vec;
  addr_t              cand_addr [NUM_WIN];
  logic               sel_hit;
  logic [3:0]         sel_idx;
  addr_t              sel_addr;
  logic [ATTR_W-1:0]  sel_attr;

  // Shadow next-state includes this cycle's write so a commit on the same edge copies it.
  always_comb begin
    for (int i = 0; i < NUM_WIN; i++) begin
      shadow_nxt[i] = shadow[i];
      if (cfg_we && cfg_win == 4'(i)) begin
        case (cfg_field)
          CFG_BASE:   shadow_nxt[i].base   = cfg_data;
          CFG_MASK:   shadow_nxt[i].mask   = cfg_data;
          CFG_TARGET: shadow_nxt[i].target = cfg_data;
          default:    shadow_nxt[i].attr   = cfg_data[ATTR_W-1:0];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (do_copy) begin
          active[i] <= shadow_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cfg_commit && !snes_idle) state_nxt = ST_PEND;
      ST_PEND: if (snes_idle)                state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    do_copy        = 1'b0;
    commit_pending = 1'b0;
    case (state)
      ST_IDLE: do_copy = cfg_commit && snes_idle;
      ST_PEND: begin
        commit_pending = 1'b1;
        do_copy        = snes_idle;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    mapper_window_match u_match (
      .addr     (SNES_ADDR),
      .win      (active[g]),
      .hit      (hit_vec[g]),
      .rom_addr (cand_addr[g])
    );
  end

  // Walk from the top so the lowest matching index is the last one written.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_addr = '0;
    sel_attr = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = 4'(i);
        sel_addr = cand_addr[i];
        sel_attr = active[i].attr;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_WRITABLE <= 1'b0;
      win_idx     <= '0;
      map_valid   <= 1'b0;
    end else begin
      ROM_ADDR    <= sel_addr;
      ROM_HIT     <= sel_hit;
      IS_SAVERAM  <= sel_attr[ATTR_SRAM];
      IS_WRITABLE <= sel_attr[ATTR_SRAM] | sel_attr[ATTR_WR];
      win_idx     <= sel_idx;
      map_valid   <= snes_req;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miss_cnt <= '0;
    end else if (cfg_clr_miss) begin
      miss_cnt <= '0;
    end else if (snes_req && !sel_hit && miss_cnt != '1) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_snes_window_mapper.sv
// Randomised plus directed bench for snes_window_mapper against an in-bench table model.
module tb_snes_window_mapper;

  localparam int NW = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] SNES_ADDR = '0;
  logic        snes_req = 1'b0;
  logic        snes_idle = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_win = '0;
  logic [1:0]  cfg_field = '0;
  logic [23:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_clr_miss = 1'b0;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT, IS_SAVERAM, IS_WRITABLE, map_valid, commit_pending;
  logic [3:0]  win_idx;
  logic [15:0] miss_cnt;

  snes_window_mapper #(.NUM_WIN(NW), .ADDR_W(24), .MISS_W(16)) dut (
    .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR), .snes_req(snes_req), .snes_idle(snes_idle),
    .cfg_we(cfg_we), .cfg_win(cfg_win), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_clr_miss(cfg_clr_miss), .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT),
    .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE), .win_idx(win_idx), .map_valid(map_valid),
    .commit_pending(commit_pending), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays for the shadow and active tables.
  logic [23:0] sh_base[16], sh_mask[16], sh_tgt[16];
  logic [3:0]  sh_attr[16];
  logic [23:0] ac_base[16], ac_mask[16], ac_tgt[16];
  logic [3:0]  ac_attr[16];
  bit          m_pend;
  int          m_miss;
  bit          e_hit, e_sram, e_wr, e_valid;
  logic [23:0] e_rom;
  logic [3:0]  e_idx;
  bit          l_hit, l_sram, l_wr, l_copy;
  logic [23:0] l_rom;
  logic [3:0]  l_idx;

  function automatic void lookup(input logic [23:0] a, output bit hit, output logic [23:0] rom,
                                 output logic [3:0] idx, output bit sram, output bit wr);
    int unsigned off;
    hit = 0; rom = '0; idx = '0; sram = 0; wr = 0;
    for (int i = 0; i < NW; i++) begin
      if (!hit && ac_attr[i][0] && ((a ^ ac_base[i]) & ac_mask[i]) == 24'h0) begin
        hit  = 1;
        idx  = 4'(i);
        off  = 32'(a & ~ac_mask[i]);
        if (ac_attr[i][3]) off = (off / 65536) * 32768 + (off % 32768);
        rom  = 24'((32'(ac_tgt[i]) + off) % 32'h0100_0000);
        sram = ac_attr[i][2];
        wr   = ac_attr[i][2] || ac_attr[i][1];
      end
    end
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        sh_base[i] = '0; sh_mask[i] = '0; sh_tgt[i] = '0; sh_attr[i] = '0;
        ac_base[i] = '0; ac_mask[i] = '0; ac_tgt[i] = '0; ac_attr[i] = '0;
      end
      m_pend = 0; m_miss = 0;
      e_hit = 0; e_sram = 0; e_wr = 0; e_valid = 0; e_rom = '0; e_idx = '0;
    end else begin
      lookup(SNES_ADDR, l_hit, l_rom, l_idx, l_sram, l_wr);
      e_hit = l_hit; e_rom = l_rom; e_idx = l_idx; e_sram = l_sram; e_wr = l_wr;
      e_valid = snes_req;
      if (cfg_clr_miss) m_miss = 0;
      else if (snes_req && !l_hit && m_miss < 65535) m_miss++;
      if (cfg_we && int'(cfg_win) < NW) begin
        case (cfg_field)
          2'd0: sh_base[cfg_win] = cfg_data;
          2'd1: sh_mask[cfg_win] = cfg_data;
          2'd2: sh_tgt[cfg_win]  = cfg_data;
          default: sh_attr[cfg_win] = cfg_data[3:0];
        endcase
      end
      l_copy = snes_idle && (m_pend || cfg_commit);
      if (!m_pend && cfg_commit && !snes_idle) m_pend = 1;
      else if (m_pend && snes_idle) m_pend = 0;
      if (l_copy) begin
        for (int i = 0; i < 16; i++) begin
          ac_base[i] = sh_base[i]; ac_mask[i] = sh_mask[i];
          ac_tgt[i] = sh_tgt[i]; ac_attr[i] = sh_attr[i];
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en && !RST) begin
      check("rom_addr", ROM_ADDR, e_rom);
      check("rom_hit", ROM_HIT, e_hit);
      check("is_saveram", IS_SAVERAM, e_sram);
      check("is_writable", IS_WRITABLE, e_wr);
      check("win_idx", win_idx, e_idx);
      check("map_valid", map_valid, e_valid);
      check("commit_pending", commit_pending, m_pend);
      check("miss_cnt", miss_cnt, m_miss);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int w, input int f, input logic [23:0] d);
    cfg_we = 1; cfg_win = 4'(w); cfg_field = 2'(f); cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
  endtask

  task automatic req(input logic [23:0] a);
    SNES_ADDR = a; snes_req = 1;
    tick();
    snes_req = 0;
  endtask

  logic [23:0] bases[5] = '{24'h000000, 24'h400000, 24'hC00000, 24'h008000, 24'h700000};
  logic [23:0] masks[5] = '{24'hC00000, 24'h800000, 24'hF00000, 24'hC08000, 24'hE08000};

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hit", ROM_HIT, 0);
    check("rst_valid", map_valid, 0);
    check("rst_pending", commit_pending, 0);
    check("rst_miss", miss_cnt, 0);
    check_en = 1;
    RST = 0;

    req(24'hC01234);
    check("t1_hit", ROM_HIT, 0);
    check("t1_valid", map_valid, 1);
    check("t1_miss", miss_cnt, 1);
    tick();
    check("t1_valid_drop", map_valid, 0);

    wr(0, 0, 24'hC00000); wr(0, 1, 24'hC00000); wr(0, 2, 24'h000000); wr(0, 3, 24'h1);
    req(24'hC12345);
    check("t2_precommit_hit", ROM_HIT, 0);
    commit();
    req(24'hC12345);
    check("t2_hit", ROM_HIT, 1);
    check("t2_rom", ROM_ADDR, 24'h012345);
    check("t2_idx", win_idx, 0);

    wr(1, 0, 24'h008000); wr(1, 1, 24'hC08000); wr(1, 2, 24'h100000); wr(1, 3, 24'h9);
    wr(9, 3, 24'h1);
    commit();
    req(24'h03ABCD);
    check("t3_model_rom", e_rom, 24'h11ABCD);
    check("t3_rom", ROM_ADDR, 24'h11ABCD);
    check("t3_idx", win_idx, 1);

    wr(0, 0, 24'h000000); wr(0, 1, 24'h800000);
    wr(2, 0, 24'h700000); wr(2, 1, 24'hF00000); wr(2, 2, 24'h200000); wr(2, 3, 24'h7);
    commit();
    req(24'h700000);
    check("t4_idx", win_idx, 0);
    check("t4_rom", ROM_ADDR, 24'h700000);
    check("t4_sram", IS_SAVERAM, 0);
    wr(0, 3, 24'h0);
    commit();
    req(24'h700000);
    check("t4b_idx", win_idx, 2);
    check("t4b_rom", ROM_ADDR, 24'h200000);
    check("t4b_sram", IS_SAVERAM, 1);
    check("t4b_wr", IS_WRITABLE, 1);

    wr(3, 0, 24'h500000); wr(3, 1, 24'hF00000); wr(3, 2, 24'h000000); wr(3, 3, 24'h1);
    snes_idle = 0;
    commit();
    for (int i = 0; i < 5; i++) begin
      cfg_commit = (i == 2);
      req(24'h500123);
      cfg_commit = 0;
      check("t5_pending", commit_pending, 1);
      check("t5_old_map", ROM_HIT, 0);
    end
    snes_idle = 1;
    wr(3, 2, 24'h010000);
    check("t5_pending_clr", commit_pending, 0);
    req(24'h500123);
    check("t5_idx", win_idx, 3);
    check("t5_rom", ROM_ADDR, 24'h010123);

    cfg_clr_miss = 1;
    tick();
    cfg_clr_miss = 0;
    check("t6_clr", miss_cnt, 0);
    SNES_ADDR = 24'h900000; snes_req = 1;
    repeat (65537) tick();
    check("t6_sat", miss_cnt, 16'hFFFF);
    cfg_clr_miss = 1;
    tick();
    cfg_clr_miss = 0; snes_req = 0;
    check("t6_clr_prio", miss_cnt, 0);
    snes_idle = 0;
    commit();
    check("t6_pend", commit_pending, 1);
    RST = 1;
    #1;
    check("t6_rst_pend", commit_pending, 0);
    tick();
    RST = 0;
    snes_idle = 1;
    req(24'h500123);
    check("t6_rst_off", ROM_HIT, 0);
    commit();
    req(24'h700000);
    check("t6_rst_shadow", ROM_HIT, 0);

    for (int n = 0; n < 3000; n++) begin
      snes_req     = 1'($urandom_range(0, 1));
      SNES_ADDR    = ($urandom_range(0, 1) == 1) ? (bases[$urandom_range(0, 4)] | 24'($urandom_range(0, 24'h0FFFFF)))
                                                 : 24'($urandom);
      snes_idle    = ($urandom_range(0, 3) != 0);
      cfg_we       = ($urandom_range(0, 2) == 0);
      cfg_win      = 4'($urandom_range(0, 9));
      cfg_field    = 2'($urandom_range(0, 3));
      case (cfg_field)
        2'd0: cfg_data = bases[$urandom_range(0, 4)];
        2'd1: cfg_data = masks[$urandom_range(0, 4)];
        2'd2: cfg_data = 24'($urandom);
        default: cfg_data = 24'($urandom_range(0, 15));
      endcase
      cfg_commit   = ($urandom_range(0, 7) == 0);
      cfg_clr_miss = ($urandom_range(0, 49) == 0);
      tick();
    end
    snes_req = 0; cfg_we = 0; cfg_commit = 0; cfg_clr_miss = 0; snes_idle = 1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
